wlce_mul_arbiter: RTL and testbench

//  Round-robin arbiter that shares one combinational 8x8 Wallace-tree multiplier (wlce)

---
 rtl/wlce_pkg.sv | 47 ++++
 rtl/wlce_mul_arbiter_rr_grant.sv | 39 +++
 rtl/wlce_mul_arbiter_wlce.sv | 28 ++
 rtl/wlce_mul_arbiter.sv | 106 ++++++++++
 tb/tb_wlce_mul_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/wlce_pkg.sv
// Shared types, widths and the round-robin pick function for the
// Wallace-tree multiplier arbiter.
package wlce_pkg;

  localparam int PROD_W  = 16;
  localparam int OP_W    = 8;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  typedef struct packed {
    logic [PROD_W-1:0] s;
    logic [PROD_W-1:0] c;
  } csa_t;

  // First set bit of vld at or above ptr, wrapping modulo n. Iterating
  // downward lets the closest candidate overwrite farther ones.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] vld,
                                    input logic [2:0] ptr, input int n);
    pick_t p;
    int    j;
    p = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= n) j = j - n;
      if (i < n && vld[j[2:0]]) begin
        p.found = 1'b1;
        p.idx   = j[2:0];
      end
    end
    return p;
  endfunction

  // Word-wide 3:2 compressor; x+y+z == s+c modulo 2^PROD_W.
  function automatic csa_t csa(input logic [PROD_W-1:0] x, y, z);
    csa_t r;
    r.s = x ^ y ^ z;
    r.c = ((x & y) | (x & z) | (y & z)) << 1;
    return r;
  endfunction

endpackage

// File: rtl/wlce_mul_arbiter_rr_grant.sv
// Round-robin grant: one-hot grant and encoded index from per-requester valid
// bits and the rotating priority pointer.
module rr_grant
  import wlce_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   idx,
  output logic             any
);

  logic [MAX_REQ-1:0] vld_pad;
  logic [2:0]         ptr_pad;
  pick_t              pick;

  always_comb begin
    vld_pad              = '0;
    vld_pad[N_REQ-1:0]   = valid;
  end

  assign ptr_pad = 3'(ptr);
  assign pick    = rr_pick(vld_pad, ptr_pad, N_REQ);
  assign any     = pick.found;

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign grant[g] = pick.found && (pick.idx == 3'(g));
  end

  always_comb begin
    idx = '0;
    for (int g = 0; g < N_REQ; g++)
      if (grant[g]) idx = idx | IDW'(g);
  end

endmodule

// File: rtl/wlce_mul_arbiter_wlce.sv
// Combinational unsigned 8x8 multiplier: partial products reduced by a
// carry-save compressor tree, one carry-propagate add at the end.
module wlce
  import wlce_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p
);

  logic [OP_W-1:0][PROD_W-1:0] pp;
  csa_t l1a, l1b, l2a, l2b, l3, l4;

  for (genvar i = 0; i < OP_W; i++) begin : g_pp
    assign pp[i] = b[i] ? (PROD_W'(a) << i) : '0;
  end

  // 8 rows -> 6 -> 4 -> 3 -> 2
  assign l1a = csa(pp[0], pp[1], pp[2]);
  assign l1b = csa(pp[3], pp[4], pp[5]);
  assign l2a = csa(l1a.s, l1a.c, l1b.s);
  assign l2b = csa(l1b.c, pp[6], pp[7]);
  assign l3  = csa(l2a.s, l2a.c, l2b.s);
  assign l4  = csa(l3.s, l3.c, l2b.c);

  assign p = l4.s + l4.c;

endmodule

// File: rtl/wlce_mul_arbiter.sv
// Round-robin arbiter sharing one registered-operand Wallace multiplier among
// N_REQ valid/ready requesters; tagged product held until rsp_ready.
module wlce_mul_arbiter
  import wlce_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int IDW    = 2,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [OP_W*N_REQ-1:0]   req_a,
  input  logic [OP_W*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic [PROD_W-1:0]       rsp_p,
  input  logic                    rsp_ready,
  output logic                    busy
);

  state_e            state, state_nxt;
  logic [3:0]        cnt;
  logic [OP_W-1:0]   op_a, op_b;
  logic [IDW-1:0]    op_id, rr_ptr;
  logic [N_REQ-1:0]  gnt;
  logic [IDW-1:0]    gnt_idx;
  logic              gnt_any, gnt_en, load, capture, retire;
  logic [PROD_W-1:0] prod;

  rr_grant #(.N_REQ(N_REQ), .IDW(IDW)) u_rr (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  wlce u_mul (.a(op_a), .b(op_b), .p(prod));

  always_comb begin
    state_nxt = state;
    gnt_en    = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    case (state)
      IDLE: begin
        gnt_en = 1'b1;
        if (gnt_any) state_nxt = MUL;
      end
      MUL: if (cnt == 4'd0) begin
        capture   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: if (rsp_ready) begin
        gnt_en    = 1'b1;
        retire    = 1'b1;
        state_nxt = gnt_any ? MUL : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Grant is suppressed while reset is held so all outputs read zero.
    gnt_en = gnt_en & ~rst;
  end

  assign load      = gnt_en & gnt_any;
  assign req_ready = gnt_en ? gnt : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_p     <= '0;
    end else begin
      if (load) begin
        op_a   <= req_a[OP_W*int'(gnt_idx) +: OP_W];
        op_b   <= req_b[OP_W*int'(gnt_idx) +: OP_W];
        op_id  <= gnt_idx;
        rr_ptr <= (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        cnt    <= 4'(SETTLE - 1);
      end else if (state == MUL && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        rsp_p     <= prod;
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end else if (retire) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wlce_mul_arbiter.sv
// Directed bench for wlce_mul_arbiter (SETTLE=1) plus a randomized
// scoreboard run against a SETTLE=3 instance.
module tb_wlce_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  int          n_chk = 0;
  int          n_fail = 0;

  // default instance
  logic [3:0]  rv;
  logic [31:0] ra, rb;
  logic [3:0]  rr;
  logic        rsv, rrdy, bsy;
  logic [1:0]  rid;
  logic [15:0] rp;

  // SETTLE=3 instance
  logic [3:0]  rv3;
  logic [31:0] ra3, rb3;
  logic [3:0]  rr3;
  logic        rsv3, rrdy3, bsy3;
  logic [1:0]  rid3;
  logic [15:0] rp3;

  always #5 clk = ~clk;

  wlce_mul_arbiter #(.N_REQ(4), .IDW(2), .SETTLE(1)) u0 (
    .clk(clk), .rst(rst), .req_valid(rv), .req_a(ra), .req_b(rb),
    .req_ready(rr), .rsp_valid(rsv), .rsp_id(rid), .rsp_p(rp),
    .rsp_ready(rrdy), .busy(bsy)
  );

  wlce_mul_arbiter #(.N_REQ(4), .IDW(2), .SETTLE(3)) u3 (
    .clk(clk), .rst(rst), .req_valid(rv3), .req_a(ra3), .req_b(rb3),
    .req_ready(rr3), .rsp_valid(rsv3), .rsp_id(rid3), .rsp_p(rp3),
    .rsp_ready(rrdy3), .busy(bsy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    ra[8*i +: 8] = a;
    rb[8*i +: 8] = b;
  endtask

  // Single request on an idle arbiter with rsp_ready=1; ends back in IDLE.
  task automatic single_op(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp);
    set_op(i, a, b);
    rv = 4'(1 << i);
    #1;
    chk("single_grant", 32'(rr), 32'(1 << i));
    tick();
    rv = '0;
    chk("single_mul_valid", 32'(rsv), 32'd0);
    tick();
    chk("single_valid", 32'(rsv), 32'd1);
    chk("single_p", 32'(rp), 32'(exp));
    chk("single_id", 32'(rid), 32'(i));
    tick();
    chk("single_idle", 32'(bsy), 32'd0);
  endtask

  logic [7:0]  ea [4];
  logic [7:0]  eb [4];
  int          r;
  logic [7:0]  a8, b8;

  initial begin
    rst = 1'b1;
    rv = 4'hF; ra = '0; rb = '0; rrdy = 1'b0;
    rv3 = '0; ra3 = '0; rb3 = '0; rrdy3 = 1'b1;
    #3;
    chk("rst_ready", 32'(rr), 32'd0);
    chk("rst_valid", 32'(rsv), 32'd0);
    chk("rst_p", 32'(rp), 32'd0);
    chk("rst_id", 32'(rid), 32'd0);
    chk("rst_busy", 32'(bsy), 32'd0);
    @(negedge clk);
    rv = '0;
    rst = 1'b0;
    tick();

    // 1: single request, 13*11, response held while rsp_ready=0
    set_op(0, 8'd13, 8'd11);
    rv = 4'b0001;
    #1;
    chk("t1_grant", 32'(rr), 32'd1);
    chk("t1_busy_idle", 32'(bsy), 32'd0);
    tick();
    rv = '0;
    #1;
    chk("t1_mul_valid", 32'(rsv), 32'd0);
    chk("t1_mul_busy", 32'(bsy), 32'd1);
    tick();
    chk("t1_valid", 32'(rsv), 32'd1);
    chk("t1_p", 32'(rp), 32'd143);
    chk("t1_id", 32'(rid), 32'd0);
    tick();
    chk("t1_hold", 32'(rsv), 32'd1);
    rrdy = 1'b1;
    tick();
    chk("t1_retire", 32'(rsv), 32'd0);
    chk("t1_idle", 32'(bsy), 32'd0);

    // 2: arithmetic corners
    single_op(1, 8'd255, 8'd255, 16'hFE01);
    single_op(2, 8'd0,   8'd200, 16'd0);
    single_op(3, 8'd128, 8'd2,   16'd256);

    // 3: all requesters valid, rotation 0,1,2,3,0,... one product per 2 cycles
    for (int i = 0; i < 4; i++) begin
      ea[i] = 8'(i + 3);
      eb[i] = 8'(10 * (i + 1));
      set_op(i, ea[i], eb[i]);
    end
    rv = 4'hF;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("t3_grant", 32'(rr), 32'(1 << (k % 4)));
      tick();
      chk("t3_mul_valid", 32'(rsv), 32'd0);
      tick();
      chk("t3_valid", 32'(rsv), 32'd1);
      chk("t3_id", 32'(rid), 32'(k % 4));
      chk("t3_p", 32'(rp), 32'(ea[k % 4]) * 32'(eb[k % 4]));
    end
    rv = '0;
    tick();
    chk("t3_idle", 32'(bsy), 32'd0);

    // 4: backpressure, then same-cycle grant to pending requester 2
    rrdy = 1'b0;
    set_op(1, 8'd20, 8'd30);
    rv = 4'b0010;
    #1;
    chk("t4_grant1", 32'(rr), 32'b0010);
    tick();
    rv = '0;
    tick();
    set_op(2, 8'd7, 8'd9);
    rv = 4'b0100;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("t4_bp_ready", 32'(rr), 32'd0);
      chk("t4_bp_valid", 32'(rsv), 32'd1);
      chk("t4_bp_p", 32'(rp), 32'd600);
      chk("t4_bp_id", 32'(rid), 32'd1);
      tick();
    end
    rrdy = 1'b1;
    #1;
    chk("t4_grant2", 32'(rr), 32'b0100);
    tick();
    rv = '0;
    chk("t4_retired", 32'(rsv), 32'd0);
    chk("t4_b2b_busy", 32'(bsy), 32'd1);
    tick();
    chk("t4_p2", 32'(rp), 32'd63);
    chk("t4_id2", 32'(rid), 32'd2);
    tick();

    // 5: wrap from pointer 3 to requester 0, then async reset mid-MUL
    set_op(0, 8'd9, 8'd9);
    rv = 4'b0001;
    #1;
    chk("t5_wrap_grant", 32'(rr), 32'b0001);
    tick();
    rv = 4'hF;
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(rsv), 32'd0);
    chk("t5_rst_p", 32'(rp), 32'd0);
    chk("t5_rst_id", 32'(rid), 32'd0);
    chk("t5_rst_busy", 32'(bsy), 32'd0);
    chk("t5_rst_ready", 32'(rr), 32'd0);
    #1;
    rst = 1'b0;
    #1;
    chk("t5_ptr0_grant", 32'(rr), 32'b0001);
    tick();
    rv = '0;
    tick();
    chk("t5_p", 32'(rp), 32'd81);
    chk("t5_id", 32'(rid), 32'd0);
    tick();

    // 6: SETTLE=3, randomized operands against a*b
    for (int n = 0; n < 1000; n++) begin
      r  = $urandom_range(0, 3);
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      ra3[8*r +: 8] = a8;
      rb3[8*r +: 8] = b8;
      rv3 = 4'(1 << r);
      #1;
      chk("t6_grant", 32'(rr3), 32'(1 << r));
      tick();
      rv3 = '0;
      tick();
      tick();
      chk("t6_lat3_valid", 32'(rsv3), 32'd0);
      tick();
      chk("t6_valid", 32'(rsv3), 32'd1);
      chk("t6_p", 32'(rp3), 32'(a8) * 32'(b8));
      chk("t6_id", 32'(rid3), 32'(r));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
